// File: rtl/fir_pkg.sv
// Shared types and default sizing for the programmable FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int DW_DEF   = 32;
    localparam int CW_DEF   = 16;
    localparam int TAPS_DEF = 16;
    localparam int FRAC_DEF = 0;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer with head pointer, fill count and flush.
module fir_delay_line #(
    parameter int DW   = 32,
    parameter int TAPS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic signed [DW-1:0]        din,
    input  logic [$clog2(TAPS)-1:0]     k,
    output logic signed [DW-1:0]        tap,
    output logic                        full
);

    localparam int IW = $clog2(TAPS);

    logic signed [DW-1:0] mem [TAPS];
    logic [IW-1:0]        head;
    logic [IW:0]          fill;
    logic [IW:0]          sum;
    logic [IW:0]          idx;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            fill <= '0;
        end else if (push) begin
            mem[head] <= din;
            head      <= (head == IW'(TAPS - 1)) ? '0 : head + IW'(1);
            if (fill != (IW+1)'(TAPS)) begin
                fill <= fill + (IW+1)'(1);
            end
        end
    end

    // Newest sample sits just behind head, so x[n-k] is at head-1-k mod TAPS.
    always_comb begin
        sum = {1'b0, head} + (IW+1)'(TAPS - 1) - {1'b0, k};
        idx = (sum >= (IW+1)'(TAPS)) ? sum - (IW+1)'(TAPS) : sum;
    end

    assign tap  = mem[IW'(idx)];
    assign full = (fill == (IW+1)'(TAPS));

endmodule

// File: rtl/fir_prog.sv
// Programmable FIR: one shared multiplier sweeps all taps per sample,
// then the accumulator is scaled, saturated and presented on y.
module fir_prog
    import fir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic signed [DW-1:0]        x,
    input  logic                        flush,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [CW-1:0]        coef_data,
    output logic                        busy,
    output logic                        valid,
    output logic signed [DW-1:0]        y
);

    localparam int IW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + IW;

    localparam logic signed [AW-1:0] MAXV =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t               state;
    logic [IW-1:0]        k;
    logic signed [AW-1:0] acc;
    logic signed [CW-1:0] coef [TAPS];
    logic signed [DW-1:0] tap;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sh;
    logic signed [DW-1:0] y_sat;
    logic                 full;
    logic                 idle;
    logic                 accept;
    logic                 flush_en;
    logic                 wr;

    assign idle     = (state == IDLE);
    assign busy     = !idle;
    assign flush_en = idle && flush;
    assign accept   = idle && enable && !flush;
    assign wr       = idle && !enable && coef_we;

    fir_delay_line #(
        .DW   (DW),
        .TAPS (TAPS)
    ) u_dl (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_en),
        .push  (accept),
        .din   (x),
        .k     (k),
        .tap   (tap),
        .full  (full)
    );

    assign prod = coef[k] * tap;
    assign sh   = acc >>> FRAC;

    always_comb begin
        y_sat = sh[DW-1:0];
        if (sh > MAXV) begin
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (sh < MINV) begin
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            acc   <= '0;
            y     <= '0;
            valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            if (wr) begin
                coef[coef_addr] <= coef_data;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    if (k == IW'(TAPS - 1)) begin
                        state <= OUT;
                    end else begin
                        k <= k + IW'(1);
                    end
                end
                OUT: begin
                    // y only moves on a real output so it holds between pulses
                    if (full) begin
                        y     <= y_sat;
                        valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_prog.sv
// Randomized scoreboard bench for fir_prog against a sum-of-products model.
module tb_fir_prog;

    localparam int TAPS = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               flush = 1'b0;
    logic               coef_we = 1'b0;
    logic signed [31:0] x = '0;
    logic [3:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               busy;
    logic               valid;
    logic signed [31:0] y;

    logic               en1 = 1'b0;
    logic               we1 = 1'b0;
    logic signed [15:0] x1 = '0;
    logic [1:0]         addr1 = '0;
    logic signed [15:0] data1 = '0;
    logic               busy1;
    logic               valid1;
    logic signed [15:0] y1;

    typedef struct {
        longint y;
        int     due;
    } exp_t;

    longint hist[$];
    longint coef_m [TAPS];
    exp_t   exp_q[$];
    int     nacc = 0;
    int     last_busy = -1;
    int     edges = 0;
    int     checks = 0;
    int     failures = 0;
    int     vcount = 0;
    longint last_y = 0;
    bit     hold_on = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    fir_prog #(.DW(32), .CW(16), .TAPS(16), .FRAC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .x         (x),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .valid     (valid),
        .y         (y)
    );

    fir_prog #(.DW(16), .CW(16), .TAPS(4), .FRAC(1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .enable    (en1),
        .x         (x1),
        .flush     (1'b0),
        .coef_we   (we1),
        .coef_addr (addr1),
        .coef_data (data1),
        .busy      (busy1),
        .valid     (valid1),
        .y         (y1)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // y[n] = sat32( sum_k coef[k] * x[n-k] ), unwritten history counts as 0
    function automatic longint model_y();
        longint s = 0;
        longint mx = (longint'(1) <<< 31) - 1;
        longint mn = -(longint'(1) <<< 31);
        for (int i = 0; i < hist.size(); i++) begin
            s += coef_m[i] * hist[i];
        end
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
        return s;
    endfunction

    task automatic cyc(input bit en, input logic signed [31:0] xv,
                       input bit fl, input bit we,
                       input logic [3:0] a, input logic signed [15:0] d);
        int   e;
        exp_t ne;
        @(negedge clk);
        e = edges;
        chk("busy", busy, e <= last_busy);
        enable = en; x = xv; flush = fl;
        coef_we = we; coef_addr = a; coef_data = d;
        if (e > last_busy) begin
            if (!en && we) coef_m[a] = d;
            if (fl) begin
                hist.delete();
                nacc = 0;
            end else if (en) begin
                hist.push_front(longint'(xv));
                if (hist.size() > TAPS) void'(hist.pop_back());
                if (nacc < TAPS) nacc++;
                last_busy = e + 1 + TAPS;
                if (nacc == TAPS) begin
                    ne.y = model_y();
                    ne.due = e + TAPS + 2;
                    exp_q.push_back(ne);
                end
            end
        end
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc(1'b0, $urandom, 1'b0, 1'b0, 4'd0, 16'sd0);
    endtask

    task automatic send(input logic signed [31:0] xv);
        cyc(1'b1, xv, 1'b0, 1'b0, 4'd0, 16'sd0);
        idle_n(TAPS + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; flush = 1'b0; coef_we = 1'b0;
        hist.delete();
        exp_q.delete();
        nacc = 0;
        last_busy = -1;
        last_y = 0;
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_y", y, 0);
    endtask

    task automatic s1_coef(input logic [1:0] a, input logic signed [15:0] d);
        @(negedge clk);
        we1 = 1'b1; addr1 = a; data1 = d;
        @(negedge clk);
        we1 = 1'b0;
    endtask

    task automatic s1_send(input logic signed [15:0] xv,
                           output bit seen, output longint yv);
        @(negedge clk);
        en1 = 1'b1; x1 = xv;
        @(negedge clk);
        en1 = 1'b0;
        seen = 1'b0;
        yv = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid1) begin
                seen = 1'b1;
                yv = longint'(y1);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            vcount++;
            chk("valid_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y", y, e.y);
                chk("latency", edges, e.due);
                last_y = e.y;
            end
        end else if (exp_q.size() > 0 && edges >= exp_q[0].due) begin
            chk("missing_valid", valid, 1);
            void'(exp_q.pop_front());
        end
        if (hold_on) begin
            chk("hold_y", y, last_y);
            chk("hold_valid", valid, 0);
        end
    end

    initial begin
        int  v0;
        bit  seen;
        longint yv;

        repeat (3) @(negedge clk);
        do_reset();

        // impulse through ramp coefficients
        for (int i = 0; i < TAPS; i++)
            cyc(1'b0, 0, 1'b0, 1'b1, 4'(i), 16'(i + 1));
        cyc(1'b0, 0, 1'b1, 1'b0, 4'd0, 16'sd0);
        for (int i = 0; i < 15; i++) send(0);
        send(1);
        for (int i = 0; i < 16; i++) send(0);

        // write attempt during MAC must not land
        cyc(1'b1, 1000, 1'b0, 1'b0, 4'd0, 16'sd0);
        cyc(1'b0, 0, 1'b0, 1'b1, 4'd0, -16'sd500);
        idle_n(TAPS);
        send(1000);

        // fill behaviour: 20 samples of 3, unit coefficients
        for (int i = 0; i < TAPS; i++)
            cyc(1'b0, 0, 1'b0, 1'b1, 4'(i), 16'sd1);
        cyc(1'b0, 0, 1'b1, 1'b0, 4'd0, 16'sd0);
        v0 = vcount;
        for (int i = 0; i < 20; i++) send(3);
        idle_n(3);
        chk("fill_pulses", vcount - v0, 5);

        hold_on = 1'b1;
        idle_n(10);
        hold_on = 1'b0;

        // random traffic
        repeat (500)
            cyc(($urandom % 4) != 0, $urandom, ($urandom % 60) == 0,
                ($urandom % 4) == 0, 4'($urandom_range(15)), 16'($urandom));

        // enable held high
        repeat (120) cyc(1'b1, $urandom, 1'b0, 1'b0, 4'd0, 16'sd0);
        idle_n(TAPS + 2);

        // reset in the middle of MAC
        cyc(1'b1, $urandom, 1'b0, 1'b0, 4'd0, 16'sd0);
        idle_n(4);
        do_reset();
        for (int i = 0; i < TAPS; i++)
            cyc(1'b0, 0, 1'b0, 1'b1, 4'(i), 16'($urandom));
        v0 = vcount;
        for (int i = 0; i < 15; i++) send($urandom);
        chk("post_rst_pulses", vcount - v0, 0);
        send($urandom);
        idle_n(3);

        // saturation and floor shift on the narrow instance
        for (int i = 0; i < 4; i++) s1_coef(2'(i), 16'sh7FFF);
        for (int i = 0; i < 3; i++) s1_send(16'sh7FFF, seen, yv);
        chk("s1_nofill", seen, 0);
        s1_send(16'sh7FFF, seen, yv);
        chk("s1_pos_seen", seen, 1);
        chk("s1_pos_sat", yv, 32767);
        for (int i = 0; i < 4; i++) s1_send(16'sh8000, seen, yv);
        chk("s1_neg_seen", seen, 1);
        chk("s1_neg_sat", yv, -32768);
        s1_coef(2'd0, 16'sd1);
        for (int i = 1; i < 4; i++) s1_coef(2'(i), 16'sd0);
        s1_send(-16'sd3, seen, yv);
        chk("s1_floor_neg", yv, -2);
        s1_send(16'sd5, seen, yv);
        chk("s1_floor_pos", yv, 2);
        chk("s1_idle", busy1, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_prog.md
FIR_PROG -- requirements
Module: fir_prog

Interface
REQ-001 Parameter DW, 32, signed sample width of x and y.
REQ-002 Parameter CW, 16, signed coefficient width.
REQ-003 Parameter TAPS, 16, filter length; legal range 2..64.
REQ-004 Parameter FRAC, 0, arithmetic right-shift applied to the accumulator before output.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  input qualifier; a sample is accepted when enable=1 and busy=0.
REQ-008 x  in  DW  signed input sample.
REQ-009 flush  in  1  clears delay line and fill count; honoured only when busy=0.
REQ-010 coef_we  in  1  coefficient write strobe.
REQ-011 coef_addr  in  clog2(TAPS)  coefficient index k, applied to x[n-k].
REQ-012 coef_data  in  CW  signed coefficient value.
REQ-013 busy  out  1  high while a sample is being processed; x is not sampled while high.
REQ-014 valid  out  1  one-cycle pulse marking y as a new output.
REQ-015 y  out  DW  signed filter output, held between valid pulses.

Function
REQ-016 FSM states IDLE, MAC, OUT; busy SHALL be 1 exactly when state is not IDLE.
REQ-017 IDLE: on enable=1, write x into the circular delay line at the head pointer, advance the head modulo TAPS, increment fill count (saturating at TAPS), clear the accumulator, go to MAC.
REQ-018 MAC: for TAPS consecutive cycles, k=0..TAPS-1, acc += coef[k]*tap[n-k], using one shared multiplier; after k=TAPS-1, go to OUT.
REQ-019 OUT: register y; assert valid for one cycle only if fill count = TAPS; return to IDLE.
REQ-020 Latency: sample accepted at edge t yields valid at edge t+TAPS+1; maximum rate is one sample per TAPS+2 cycles.
REQ-021 The first TAPS-1 accepted samples after reset or flush SHALL produce no valid pulse.
REQ-022 Accumulator width is DW+CW+clog2(TAPS); no intermediate overflow permitted.
REQ-023 y = acc >>> FRAC (floor), then saturated to signed DW range [-2^(DW-1), 2^(DW-1)-1].
REQ-024 coef_we in IDLE with enable=0 writes coef[coef_addr] on that edge; coef_we while busy=1 or together with an accepted sample SHALL be ignored.
REQ-025 flush with enable=1 in IDLE: flush wins; no sample is accepted that cycle.
REQ-026 enable=0 in IDLE: all state held, valid=0, y held.
REQ-027 Delay-line entries not yet written since reset/flush read as 0.

Reset
REQ-028 rst=1 on an edge SHALL force state IDLE, busy=0, valid=0, y=0, fill count=0, head=0, accumulator=0, all delay-line entries and coefficients=0, from any state including mid-MAC.
REQ-029 A sample in progress when rst asserts SHALL be discarded with no valid pulse.

Structure
REQ-030 A shared package fir_pkg SHALL hold the FSM state typedef and default parameter constants.
REQ-031 The delay line (circular buffer, head pointer, fill count, flush) SHALL be one sub-module, fir_delay_line; FSM, MAC and coefficient file stay in the top.

Verification
REQ-032 Impulse: coef[k]=k+1, feed 1 then 0s (TAPS=16, FRAC=0) -> after fill, output sequence 1,2,...,16 then 0s at valid pulses.
REQ-033 Fill: feed 20 samples of value 3 with coef all 1 -> exactly 5 valid pulses, each y=48, first valid at acceptance of sample 16 plus 17 cycles.
REQ-034 Saturation: DW=16, coef all 0x7FFF, x all 0x7FFF -> y=0x7FFF; x all 0x8000 -> y=0x8000.
REQ-035 Protected write: coef_we asserted during MAC with new value -> coefficient unchanged, next output uses old value.
REQ-036 Reset mid-MAC: rst for one cycle at MAC cycle 5 -> no valid from that sample, busy=0 and y=0 next cycle, next 15 samples produce no valid.
REQ-037 Throughput/hold: enable held 1 -> busy period exactly TAPS+1 cycles, x ignored while busy; enable 0 for 10 cycles -> y stable, valid 0.
